// File: rtl/fu_issue_ctrl.sv
// fu_issue_ctrl
//   Issue controller for a single multi-cycle functional unit (FU).
//   Requests are buffered in a 2-entry FIFO, issued one at a time to the
//   FU, and the FU result is held for a writeback handshake. A watchdog
//   aborts an operation whose completion never arrives.
//
// Ports
//   clk, rst                  clock; asynchronous active-low reset
//   in_valid/in_ready         issue request handshake
//   in_op0, in_op1, in_tag    request operands and destination tag
//   fu_ce                     one-cycle start pulse to the FU
//   fu_data_0, fu_data_1      operands presented to the FU
//   fu_idle, fu_done          FU can accept / FU has completed
//   fu_result                 FU result, captured on completion
//   wb_valid/wb_ready         writeback handshake
//   wb_result, wb_tag         captured result and its tag
//   busy                      queue non-empty or an operation in flight
//   timeout_err               sticky watchdog abort flag
module fu_issue_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_op0,
    input  logic [DATA_WIDTH-1:0] in_op1,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  fu_ce,
    output logic [DATA_WIDTH-1:0] fu_data_0,
    output logic [DATA_WIDTH-1:0] fu_data_1,
    input  logic                  fu_idle,
    input  logic                  fu_done,
    input  logic [DATA_WIDTH-1:0] fu_result,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [DATA_WIDTH-1:0] wb_result,
    output logic [TAG_WIDTH-1:0]  wb_tag,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_WB    = 2'd3;

    localparam int         ENTRY_W = 2 * DATA_WIDTH + TAG_WIDTH;
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    logic [1:0]            state;
    logic [ENTRY_W-1:0]    q_mem [2];
    logic                  q_wr_ptr;
    logic                  q_rd_ptr;
    logic [1:0]            q_count;
    logic [ENTRY_W-1:0]    q_head;
    logic                  push;
    logic                  pop;
    logic [TAG_WIDTH-1:0]  issue_tag;
    logic [7:0]            wd_cnt;

    // in_ready depends only on the registered count, never on inputs.
    assign in_ready = (q_count != 2'd2);
    assign push     = in_valid && in_ready;
    assign q_head   = q_mem[q_rd_ptr];

    // Head is taken from IDLE, or straight from WB when the writeback
    // completes and the FU is ready (back-to-back issue).
    assign pop = (q_count != 2'd0) && fu_idle &&
                 ((state == ST_IDLE) || ((state == ST_WB) && wb_ready));

    assign fu_ce    = (state == ST_ISSUE);
    assign wb_valid = (state == ST_WB);
    assign busy     = (q_count != 2'd0) || (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[q_wr_ptr] <= {in_op0, in_op1, in_tag};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_wr_ptr <= 1'b0;
            q_rd_ptr <= 1'b0;
            q_count  <= 2'd0;
        end else begin
            if (push) q_wr_ptr <= ~q_wr_ptr;
            if (pop)  q_rd_ptr <= ~q_rd_ptr;
            case ({push, pop})
                2'b10:   q_count <= q_count + 2'd1;
                2'b01:   q_count <= q_count - 2'd1;
                default: q_count <= q_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            fu_data_0   <= '0;
            fu_data_1   <= '0;
            issue_tag   <= '0;
            wb_result   <= '0;
            wb_tag      <= '0;
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (pop) begin
                {fu_data_0, fu_data_1, issue_tag} <= q_head;
            end
            case (state)
                ST_IDLE: begin
                    if (pop) state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    state  <= ST_WAIT;
                    wd_cnt <= '0;
                end
                ST_WAIT: begin
                    // Completion is checked first so a done arriving in the
                    // final watchdog cycle still produces a writeback.
                    if (fu_done) begin
                        state     <= ST_WB;
                        wb_result <= fu_result;
                        wb_tag    <= issue_tag;
                    end else if (wd_cnt == WD_LAST) begin
                        state       <= ST_IDLE;
                        timeout_err <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
                end
                default: begin
                    if (wb_ready) state <= pop ? ST_ISSUE : ST_IDLE;
                end
            endcase
        end
    end

endmodule
